// File: rtl/apb_slv_pkg.sv
// Shared definitions for the APB slave register bank: FSM state encoding,
// register map indices/offsets, field widths and a saturating increment.
package apb_slv_pkg;

    // Transfer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } apb_state_e;

    // Width of the CTRL.WAIT_CYC field.
    localparam int WAIT_W = 4;

    // Width of each STATUS counter.
    localparam int CNT_W = 16;

    // Register word indices.
    localparam int REG_CTRL         = 0;
    localparam int REG_ID           = 1;
    localparam int REG_STATUS       = 2;
    localparam int REG_SCRATCH_BASE = 3;

    // Register byte offsets.
    localparam logic [7:0] OFF_CTRL         = 8'h00;
    localparam logic [7:0] OFF_ID           = 8'h04;
    localparam logic [7:0] OFF_STATUS       = 8'h08;
    localparam logic [7:0] OFF_SCRATCH_BASE = 8'h0C;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// Register storage for the APB slave: CTRL, constant ID, saturating STATUS
// counters and scratch words. Writes and counter updates happen only on the
// commit strobe; ID and STATUS are never writable, whatever the caller asks.
module apb_slv_regfile
    import apb_slv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001,
    localparam int                   IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  commit_i,
    input  logic                  err_i,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [WAIT_W-1:0]     wait_cyc_o
);

    localparam int NUM_SCRATCH = DEPTH - REG_SCRATCH_BASE;

    logic [WAIT_W-1:0]     ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] scratch_q [NUM_SCRATCH];
    logic [DATA_WIDTH-1:0] scratch_d [NUM_SCRATCH];
    logic [CNT_W-1:0]      xfer_cnt_q, xfer_cnt_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;

    // Next-state for storage and counters on a committed transfer.
    always_comb begin
        ctrl_d     = ctrl_q;
        scratch_d  = scratch_q;
        xfer_cnt_d = xfer_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (commit_i) begin
            xfer_cnt_d = sat_inc(xfer_cnt_q);
            if (err_i) begin
                err_cnt_d = sat_inc(err_cnt_q);
            end
        end
        if (wr_en_i) begin
            if (wr_idx_i == IDX_W'(REG_CTRL)) begin
                ctrl_d = wr_data_i[WAIT_W-1:0];
            end
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (wr_idx_i == IDX_W'(REG_SCRATCH_BASE + i)) begin
                    scratch_d[i] = wr_data_i;
                end
            end
        end
    end

    // Storage registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            scratch_q  <= '{default: '0};
            xfer_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            scratch_q  <= scratch_d;
            xfer_cnt_q <= xfer_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Read mux over the whole map; unmapped indices read as zero.
    always_comb begin
        rd_data_o = '0;
        if (rd_idx_i == IDX_W'(REG_CTRL)) begin
            rd_data_o = DATA_WIDTH'(ctrl_q);
        end else if (rd_idx_i == IDX_W'(REG_ID)) begin
            rd_data_o = ID_VALUE;
        end else if (rd_idx_i == IDX_W'(REG_STATUS)) begin
            rd_data_o = DATA_WIDTH'({err_cnt_q, xfer_cnt_q});
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (rd_idx_i == IDX_W'(REG_SCRATCH_BASE + i)) begin
                    rd_data_o = scratch_q[i];
                end
            end
        end
    end

    assign wait_cyc_o = ctrl_q;

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave register bank with programmable wait states.
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0), then
// access cycles (PSEL=1, PENABLE=1) until PREADY is 1 for exactly one cycle;
// PRDATA/PSLVERR are meaningful only in that cycle, and the transfer commits
// on the edge that ends it only if PSEL and PENABLE are still high. Dropping
// PSEL before that aborts the transfer with no side effects.
module apb_slave_regbank
    import apb_slv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL_slv_i,
    input  logic                  PENABLE_slv_i,
    input  logic                  PWRITE_slv_i,
    input  logic [ADDR_WIDTH-1:0] PADDR_slv_i,
    input  logic [DATA_WIDTH-1:0] PWDATA_slv_i,
    output logic [DATA_WIDTH-1:0] PRDATA_slv_o,
    output logic                  PREADY_slv_o,
    output logic                  PSLVERR_slv_o,
    output logic [1:0]            state_dbg_o
);

    localparam int IDX_W = $clog2(DEPTH);

    apb_state_e            state_q, state_d;
    logic [WAIT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;

    logic [IDX_W-1:0]      setup_idx;
    logic                  setup_err;
    logic [IDX_W-1:0]      rd_idx;
    logic                  resp_err;
    logic                  resp_write;
    logic                  enter_ready;
    logic                  commit;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [WAIT_W-1:0]     wait_cyc;

    // Decode the live setup-phase address: word index and error conditions.
    always_comb begin
        setup_idx = PADDR_slv_i[IDX_W+1:2];
        setup_err = (PADDR_slv_i[1:0] != 2'b00)
                 || (PADDR_slv_i >= ADDR_WIDTH'(DEPTH * 4))
                 || (PWRITE_slv_i && ((setup_idx == IDX_W'(REG_ID))
                                   || (setup_idx == IDX_W'(REG_STATUS))));
        // In IDLE the capture and the READY entry can share an edge, so the
        // response must come from the live bus rather than the latches.
        rd_idx     = (state_q == ST_IDLE) ? setup_idx    : idx_q;
        resp_err   = (state_q == ST_IDLE) ? setup_err    : err_q;
        resp_write = (state_q == ST_IDLE) ? PWRITE_slv_i : write_q;
    end

    // Transfer FSM: next state, setup capture, wait countdown and response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        prdata_d    = '0;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        enter_ready = 1'b0;
        commit      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PSEL_slv_i && !PENABLE_slv_i) begin
                    idx_d   = setup_idx;
                    write_d = PWRITE_slv_i;
                    wdata_d = PWDATA_slv_i;
                    err_d   = setup_err;
                    cnt_d   = wait_cyc - WAIT_W'(1);
                    if (wait_cyc == '0) begin
                        state_d     = ST_READY;
                        enter_ready = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!PSEL_slv_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d     = ST_READY;
                    enter_ready = 1'b1;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            ST_READY: begin
                commit  = PSEL_slv_i && PENABLE_slv_i;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (enter_ready) begin
            pready_d  = 1'b1;
            pslverr_d = resp_err;
            prdata_d  = (resp_err || resp_write) ? '0 : rd_data;
        end
    end

    // FSM, transfer latches and registered APB response.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign wr_en = commit && write_q && !err_q;

    apb_slv_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ID_VALUE   (ID_VALUE)
    ) u_regfile (
        .clk        (PCLK),
        .rst_n      (PRESETn),
        .commit_i   (commit),
        .err_i      (err_q),
        .wr_en_i    (wr_en),
        .wr_idx_i   (idx_q),
        .wr_data_i  (wdata_q),
        .rd_idx_i   (rd_idx),
        .rd_data_o  (rd_data),
        .wait_cyc_o (wait_cyc)
    );

    assign PRDATA_slv_o  = prdata_q;
    assign PREADY_slv_o  = pready_q;
    assign PSLVERR_slv_o = pslverr_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: directed scenarios plus randomized traffic,
// checked against a word-level model of the register map through an
// expected-response queue drained by an independent monitor.
`timescale 1ns/1ps
module tb_apb_slave_regbank;
    import apb_slv_pkg::*;

    localparam logic [31:0] ID_VAL = 32'hA9B0_0001;

    // ---------------- clock / reset ----------------
    logic        pclk    = 1'b0;
    logic        presetn = 1'b0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] paddr   = '0;
    logic [31:0] pwdata  = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [1:0]  state_dbg;

    always #5 pclk = ~pclk;

    apb_slave_regbank dut (
        .PCLK          (pclk),
        .PRESETn       (presetn),
        .PSEL_slv_i    (psel),
        .PENABLE_slv_i (penable),
        .PWRITE_slv_i  (pwrite),
        .PADDR_slv_i   (paddr),
        .PWDATA_slv_i  (pwdata),
        .PRDATA_slv_o  (prdata),
        .PREADY_slv_o  (pready),
        .PSLVERR_slv_o (pslverr),
        .state_dbg_o   (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [16];
    logic [3:0]  m_ctrl;
    logic [15:0] m_xfer;
    logic [15:0] m_errc;

    task automatic m_reset();
        foreach (m_mem[i]) m_mem[i] = '0;
        m_ctrl = '0;
        m_xfer = '0;
        m_errc = '0;
    endtask

    function automatic logic m_is_err(input logic [31:0] a, input logic w);
        return (a % 4 != 0) || (a >= 32'd64) || (w && (a == 32'h4 || a == 32'h8));
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int w;
        w = int'(a / 4);
        if (w == 0) return {28'd0, m_ctrl};
        if (w == 1) return ID_VAL;
        if (w == 2) return {m_errc, m_xfer};
        return m_mem[w];
    endfunction

    task automatic m_commit(input logic [31:0] a, input logic w, input logic [31:0] d, input logic err);
        if (m_xfer < 16'hFFFF) m_xfer = m_xfer + 16'd1;
        if (err && m_errc < 16'hFFFF) m_errc = m_errc + 16'd1;
        if (!err && w) begin
            if (a == 32'h0) m_ctrl = d[3:0];
            else m_mem[a / 4] = d;
        end
    endtask

    // ---------------- scoreboard queue ----------------
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  lat;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- driver tasks ----------------
    // Called and returning at posedge+1; drives one full transfer.
    task automatic apb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input bit do_abort);
        exp_t e;
        logic err;
        bit   seen;
        err = m_is_err(a, w);
        if (!do_abort) begin
            e.err   = err;
            e.rdata = (err || w) ? 32'd0 : m_read(a);
            e.lat   = 5'(m_ctrl) + 5'd1;
            exp_q.push_back(e);
            m_commit(a, w, d, err);
        end
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        if (do_abort) begin
            repeat (2) @(posedge pclk);
            #1;
            psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
            repeat (3) @(posedge pclk);
            #1;
            return;
        end
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge pclk);
            if (pready) seen = 1'b1;
        end
        check("ready_seen", 32'(seen), 32'd1);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // ---------------- monitor ----------------
    int acc_cnt = 0;
    always @(negedge pclk) begin
        exp_t e;
        if (!presetn) begin
            acc_cnt = 0;
        end else begin
            if (psel && penable) acc_cnt++;
            else acc_cnt = 0;
            if (pready) begin
                if (exp_q.size() == 0) begin
                    check("pready_unexpected", 32'(pready), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("prdata", prdata, e.rdata);
                    check("pslverr", 32'(pslverr), 32'(e.err));
                    check("latency", 32'(acc_cnt), 32'(e.lat));
                end
            end else begin
                check("idle_prdata", prdata, 32'd0);
                check("idle_pslverr", 32'(pslverr), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic        w;
        m_reset();
        presetn = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset_prdata", prdata, 32'd0);
        check("reset_pready", 32'(pready), 32'd0);
        check("reset_pslverr", 32'(pslverr), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        presetn = 1'b1;
        idle(1);

        // Zero-wait write, read back, STATUS.
        apb_xfer(32'(OFF_SCRATCH_BASE), 1'b1, 32'hDEAD_BEEF, 1'b0);
        apb_xfer(32'(OFF_SCRATCH_BASE), 1'b0, 32'd0, 1'b0);
        apb_xfer(32'(OFF_STATUS), 1'b0, 32'd0, 1'b0);
        idle(1);

        // Wait states.
        apb_xfer(32'(OFF_CTRL), 1'b1, 32'd3, 1'b0);
        apb_xfer(32'(OFF_ID), 1'b0, 32'd0, 1'b0);
        idle(1);

        // Error transfers.
        apb_xfer(32'h40, 1'b0, 32'd0, 1'b0);
        apb_xfer(32'h05, 1'b1, 32'hCAFE, 1'b0);
        apb_xfer(32'(OFF_ID), 1'b1, 32'h1234, 1'b0);
        apb_xfer(32'(OFF_ID), 1'b0, 32'd0, 1'b0);
        apb_xfer(32'(OFF_STATUS), 1'b0, 32'd0, 1'b0);
        idle(2);

        // Abort in the third access cycle.
        apb_xfer(32'(OFF_CTRL), 1'b1, 32'd7, 1'b0);
        apb_xfer(32'h10, 1'b1, 32'h55, 1'b1);
        apb_xfer(32'h10, 1'b0, 32'd0, 1'b0);
        apb_xfer(32'(OFF_STATUS), 1'b0, 32'd0, 1'b0);
        idle(1);

        // Reset asserted while waiting.
        apb_xfer(32'(OFF_CTRL), 1'b1, 32'd5, 1'b0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h77;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        check("mid_wait_state", 32'(state_dbg), 32'(ST_WAIT));
        presetn = 1'b0;
        #1;
        check("rst_prdata", prdata, 32'd0);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        m_reset();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        idle(2);
        presetn = 1'b1;
        idle(1);
        apb_xfer(32'(OFF_CTRL), 1'b0, 32'd0, 1'b0);
        apb_xfer(32'h20, 1'b0, 32'd0, 1'b0);
        idle(1);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                apb_xfer(32'(OFF_CTRL), 1'b1, 32'($urandom_range(0, 4)), 1'b0);
            end else begin
                a = 32'($urandom_range(0, 19)) * 32'd4;
                if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
                w = 1'($urandom_range(0, 1));
                if (m_ctrl >= 4'd3 && $urandom_range(0, 7) == 0)
                    apb_xfer(a, w, $urandom, 1'b1);
                else
                    apb_xfer(a, w, $urandom, 1'b0);
            end
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(2);

        // Counter saturation via backdoor preload.
        force dut.u_regfile.xfer_cnt_q = 16'hFFFE;
        force dut.u_regfile.err_cnt_q  = 16'hFFFE;
        #1;
        release dut.u_regfile.xfer_cnt_q;
        release dut.u_regfile.err_cnt_q;
        m_xfer = 16'hFFFE;
        m_errc = 16'hFFFE;
        apb_xfer(32'h40, 1'b0, 32'd0, 1'b0);
        apb_xfer(32'h0C, 1'b1, 32'h1111_2222, 1'b0);
        apb_xfer(32'(OFF_STATUS), 1'b1, 32'd9, 1'b0);
        apb_xfer(32'(OFF_STATUS), 1'b0, 32'd0, 1'b0);

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_slave_regbank.md
# apb_slave_regbank

APB slave register bank on the far side of the `apb_master` bus; it consumes PSEL/PENABLE/PADDR/PWRITE/PWDATA and returns PRDATA/PREADY/PSLVERR. It provides 16 words of control, status and scratch storage and inserts a programmable number of wait states. It also exercises the master's PREADY, PSLVERR and timeout paths. Aborted transfers, where the master drops PSEL after a timeout, are handled cleanly.

## Interface
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- DEPTH, 16, number of 32-bit words; byte-addressed, word-aligned.
- ID_VALUE, 32'hA9B0_0001, read-only identification word.
- PCLK  in  1  clock; everything is sampled on the rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- PSEL_slv_i  in  1  select.
- PENABLE_slv_i  in  1  access-phase enable.
- PWRITE_slv_i  in  1  1 = write, 0 = read.
- PADDR_slv_i  in  ADDR_WIDTH  byte address.
- PWDATA_slv_i  in  DATA_WIDTH  write data.
- PRDATA_slv_o  out  DATA_WIDTH  read data; registered.
- PREADY_slv_o  out  1  transfer-complete strobe; registered.
- PSLVERR_slv_o  out  1  error response; registered, valid only while PREADY_slv_o is 1.

## Operation
Register map (word index, byte offset):
- 0 CTRL (0x00): RW. Bits [3:0] are WAIT_CYC; the upper bits read 0. Reset value 0.
- 1 ID (0x04): RO, returns ID_VALUE.
- 2 STATUS (0x08): RO. Bits [15:0] are XFER_CNT (completed transfers). Bits [31:16] are ERR_CNT (error transfers). Both saturate at 0xFFFF. Reset value 0.
- 3..15 SCRATCH: RW, reset value 0.

Error decode is computed in the setup cycle. The transfer is an error if any of the following holds:
- PADDR[1:0] != 0;
- PADDR >= DEPTH*4;
- it is a write to ID or STATUS.

Error transfers have no side effects: no register write. They return PRDATA = 0 and PSLVERR = 1.

State machine (IDLE, WAIT, READY):
- **IDLE.** The block captures the setup phase when PSEL=1 and PENABLE=0. In that cycle it latches the address, direction, write data and error flag. It also loads cnt = WAIT_CYC-1 (from the CTRL value at setup). It then goes to READY if WAIT_CYC=0, otherwise to WAIT. PENABLE=1 while in IDLE is ignored.
- **WAIT.** If PSEL=0 (abort), go to IDLE. Else if cnt=0, go to READY. Else cnt decrements.
- **READY.** PREADY=1 for exactly one cycle. If PSEL=1 and PENABLE=1, the transfer commits:
  - a non-error write updates the register;
  - XFER_CNT increments;
  - ERR_CNT also increments if the transfer is an error.
  
  If PSEL=0 in this cycle, nothing commits. The next state is always IDLE.
- **PRDATA/PSLVERR loading.** Both are loaded on the edge that enters READY. PRDATA is the read value for a non-error read, otherwise 0. Both return to 0 on leaving READY.
- **CTRL timing.** A write to CTRL affects the next transfer, never the current one.
- **Back-to-back transfers.** A new setup is accepted in the cycle after READY.

## Timing
- Reset values: PREADY_slv_o=0, PSLVERR_slv_o=0, PRDATA_slv_o=0, state=IDLE, CTRL=0, STATUS=0, scratch words=0.
- Access-phase length: WAIT_CYC+1 cycles. PREADY rises in the Nth access cycle, where N = WAIT_CYC+1.
- With WAIT_CYC=0, PREADY=1 in the first access cycle (zero-wait APB).
- Write commit: on the PCLK edge that ends the READY cycle.
- Read data: stable for the whole READY cycle.
- Abort: PSEL low in WAIT or READY returns to IDLE within one cycle, with no write and no counter change.
- Reset asserted mid-transfer clears all state immediately.
- Saturation: at 0xFFFF, an increment leaves the counter unchanged.

## Structure
- Package `apb_slv_pkg` holds:
  - the state encoding (IDLE/WAIT/READY);
  - the register indices and byte offsets (CTRL, ID, STATUS, SCRATCH_BASE);
  - the WAIT_CYC field width.
- Sub-module `apb_slv_regfile`:
  - contains the DEPTH-word storage, the write port with read-only protection, and the read mux;
  - contains the saturating STATUS counters;
  - is driven by the commit strobe from the FSM in `apb_slave_regbank`.

## Test plan
- **Zero-wait write then read.** With CTRL=0, write 0xDEADBEEF to 0x0C, then read 0x0C. Required: PREADY in the first access cycle both times; PRDATA=0xDEADBEEF; PSLVERR=0; STATUS=0x0000_0002.
- **Wait states.** Write CTRL=3, then read 0x04. Required: PREADY in the 4th access cycle; PRDATA=0xA9B0_0001.
- **Errors.** Issue three transfers: a read of 0x40 (out of range), a write to 0x05 (unaligned), and a write of 0x1234 to 0x04 (read-only ID). Required: each returns PSLVERR=1 and PRDATA=0; a following read of ID still returns 0xA9B0_0001; ERR_CNT=3.
- **Abort.** With CTRL=7, start a write of 0x55 to 0x10 and drop PSEL in the 3rd access cycle. Required: PREADY never asserts; 0x10 reads 0; XFER_CNT is unchanged.
- **Reset mid-WAIT.** With CTRL=5, assert PRESETn=0 during WAIT. Required: all outputs are 0 immediately and CTRL reads 0 afterwards.
- **Saturation.** Preload the counters to 0xFFFE through a force/backdoor, then run 3 transfers. Required: XFER_CNT=0xFFFF.
